i2c_byte_ctrl: RTL and testbench

Byte-level sequencer for the I2C bit generator. It accepts START / STOP / WRITE-byte / READ-byte commands over a valid/ready handshake. It issues the nine single-bit requests per byte (8 data bits MSB first, then the ACK bit) to the bit generator, and hands START/STOP to the bus-condition generator. It sits between the sensor register-access FSM and the I2C physical layer.

---
 rtl/i2c_byte_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_byte_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl
//   Byte-level sequencer in front of the I2C bit generator. Accepts START /
//   STOP / WRITE / READ commands over a valid/ready handshake. A byte becomes
//   nine single-bit requests (8 data bits MSB first, then the ACK bit).
//   START and STOP are passed to the bus-condition generator.
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in any single wait state before aborting
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd, i_wr_data, i_rd_ack   command handshake
//   o_done, o_rd_data, o_ack_rcvd, o_err                  completion status
//   o_bit_req, o_bit_we, o_bit_wr, i_bit_ready,
//   i_bit_rd_valid, i_bit_rd                              bit generator side
//   o_cond_req, o_cond_stop, i_cond_done                  bus-condition side
module i2c_byte_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_ack,
  output logic       o_done,
  output logic [7:0] o_rd_data,
  output logic       o_ack_rcvd,
  output logic       o_err,
  output logic       o_bit_req,
  output logic       o_bit_we,
  output logic       o_bit_wr,
  input  logic       i_bit_ready,
  input  logic       i_bit_rd_valid,
  input  logic       i_bit_rd,
  output logic       o_cond_req,
  output logic       o_cond_stop,
  input  logic       i_cond_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COND,
    S_BIT_REQ,
    S_BIT_BUSY,
    S_BIT_DONE,
    S_DONE
  } state_t;

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [1:0]      cmd_q;
  logic [7:0]      data_q;
  logic            rd_ack_q;
  logic [3:0]      cnt_q;
  logic [WD_W-1:0] wdog_q;
  logic [7:0]      rd_data_q;
  logic            ack_rcvd_q;
  logic            err_q;

  logic accept;
  logic abort;
  logic wait_st;
  logic timeout;
  logic in_bit;
  logic last_bit;
  logic is_read;

  assign last_bit = (cnt_q == 4'd8);
  // Only WRITE (10) and READ (11) reach the bit states, so bit 0 tells them apart.
  assign is_read  = cmd_q[0];

  always_comb begin
    wait_st = (state_q == S_COND) || (state_q == S_BIT_REQ) ||
              (state_q == S_BIT_BUSY) || (state_q == S_BIT_DONE);
    in_bit  = (state_q == S_BIT_REQ) || (state_q == S_BIT_BUSY) ||
              (state_q == S_BIT_DONE);
    timeout = wait_st && (wdog_q == WD_LAST);
  end

  // Next state. A normal exit condition takes priority over a timeout that
  // expires in the same cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          accept  = 1'b1;
          state_d = i_cmd[1] ? S_BIT_REQ : S_COND;
        end
      end
      S_COND: begin
        if (i_cond_done) begin
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
          abort   = 1'b1;
        end
      end
      S_BIT_REQ: begin
        if (i_bit_ready) begin
          state_d = S_BIT_BUSY;
        end else if (timeout) begin
          state_d = S_DONE;
          abort   = 1'b1;
        end
      end
      S_BIT_BUSY: begin
        if (!i_bit_ready) begin
          state_d = S_BIT_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
          abort   = 1'b1;
        end
      end
      S_BIT_DONE: begin
        if (i_bit_ready) begin
          state_d = last_bit ? S_DONE : S_BIT_REQ;
        end else if (timeout) begin
          state_d = S_DONE;
          abort   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state so that an asynchronous reset
  // returns them to their idle values immediately.
  always_comb begin
    o_cmd_ready = (state_q == S_IDLE);
    o_done      = (state_q == S_DONE);
    o_bit_req   = (state_q == S_BIT_REQ);
    o_cond_req  = (state_q == S_COND);
    o_cond_stop = (state_q == S_COND) && cmd_q[0];
    o_bit_we    = 1'b0;
    o_bit_wr    = 1'b0;
    if (in_bit) begin
      if (!is_read) begin
        if (!last_bit) begin
          o_bit_we = 1'b1;
          o_bit_wr = data_q[3'd7 - cnt_q[2:0]];
        end
      end else if (last_bit) begin
        o_bit_we = 1'b1;
        o_bit_wr = ~rd_ack_q;
      end
    end
    o_rd_data  = rd_data_q;
    o_ack_rcvd = ack_rcvd_q;
    o_err      = err_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      data_q     <= '0;
      rd_ack_q   <= 1'b0;
      cnt_q      <= '0;
      wdog_q     <= '0;
      rd_data_q  <= '0;
      ack_rcvd_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_d != state_q) || !wait_st) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + WD_W'(1);
      end

      if (accept) begin
        cmd_q    <= i_cmd;
        data_q   <= i_wr_data;
        rd_ack_q <= i_rd_ack;
        cnt_q    <= '0;
        err_q    <= 1'b0;
      end

      if ((state_q == S_BIT_DONE) && i_bit_ready && !last_bit) begin
        cnt_q <= cnt_q + 4'd1;
      end

      if (abort) begin
        err_q <= 1'b1;
      end

      if (((state_q == S_BIT_BUSY) || (state_q == S_BIT_DONE)) && i_bit_rd_valid) begin
        if (is_read && !last_bit) begin
          rd_data_q <= {rd_data_q[6:0], i_bit_rd};
        end
        if (!is_read && last_bit) begin
          ack_rcvd_q <= ~i_bit_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
module tb_i2c_byte_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [1:0] i_cmd;
  logic [7:0] i_wr_data;
  logic       i_rd_ack;
  logic       o_done;
  logic [7:0] o_rd_data;
  logic       o_ack_rcvd;
  logic       o_err;
  logic       o_bit_req;
  logic       o_bit_we;
  logic       o_bit_wr;
  logic       i_bit_ready;
  logic       i_bit_rd_valid;
  logic       i_bit_rd;
  logic       o_cond_req;
  logic       o_cond_stop;
  logic       i_cond_done;

  i2c_byte_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd          (i_cmd),
    .i_wr_data      (i_wr_data),
    .i_rd_ack       (i_rd_ack),
    .o_done         (o_done),
    .o_rd_data      (o_rd_data),
    .o_ack_rcvd     (o_ack_rcvd),
    .o_err          (o_err),
    .o_bit_req      (o_bit_req),
    .o_bit_we       (o_bit_we),
    .o_bit_wr       (o_bit_wr),
    .i_bit_ready    (i_bit_ready),
    .i_bit_rd_valid (i_bit_rd_valid),
    .i_bit_rd       (i_bit_rd),
    .o_cond_req     (o_cond_req),
    .o_cond_stop    (o_cond_stop),
    .i_cond_done    (i_cond_done)
  );

  int tests = 0;
  int fails = 0;

  // Environment knobs set by the main sequence.
  bit stall    = 0;
  int bit_time = 2;
  int slow     = 0;
  int cond_dly = 0;

  // Observations from the bus-side models.
  bit req_we[$];
  bit req_wr[$];
  bit cond_log[$];
  bit sda_q[$];
  int req_rises = 0;
  int overlap   = 0;

  // Reference state: what the status outputs should hold.
  logic [7:0] model_rd  = 8'h00;
  logic       model_ack = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Bit generator + slave: accepts a request while ready, optionally keeps
  // ready high for a while, then runs a low phase and returns the sampled bit.
  initial begin
    bit b;
    i_bit_ready    = 1'b1;
    i_bit_rd_valid = 1'b0;
    i_bit_rd       = 1'b0;
    forever begin
      @(negedge clk);
      if (stall) begin
        i_bit_ready = 1'b0;
      end else begin
        i_bit_ready = 1'b1;
        if (o_bit_req) begin
          req_we.push_back(o_bit_we);
          req_wr.push_back(o_bit_wr);
          if (o_bit_we) b = o_bit_wr;
          else if (sda_q.size() > 0) b = sda_q.pop_front();
          else b = 1'b1;
          repeat (slow) @(negedge clk);
          @(negedge clk);
          i_bit_ready = 1'b0;
          repeat (bit_time - 1) @(negedge clk);
          i_bit_rd_valid = 1'b1;
          i_bit_rd       = b;
          @(negedge clk);
          i_bit_rd_valid = 1'b0;
          i_bit_ready    = 1'b1;
        end
      end
    end
  end

  // Bus-condition generator.
  initial begin
    i_cond_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_cond_req) begin
        cond_log.push_back(o_cond_stop);
        repeat (cond_dly) @(negedge clk);
        i_cond_done = 1'b1;
        @(negedge clk);
        i_cond_done = 1'b0;
      end
    end
  end

  // Request edge counter and request overlap monitor.
  initial begin
    bit prev = 0;
    forever begin
      @(negedge clk);
      if (o_bit_req && !prev) req_rises++;
      if (o_bit_req && o_cond_req) overlap++;
      prev = o_bit_req;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] c, input logic [7:0] wd, input logic ra);
    int n = 0;
    while (!o_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_cmd", {31'd0, o_cmd_ready}, 1);
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    i_wr_data   = wd;
    i_rd_ack    = ra;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd       = $urandom_range(3, 0);
    i_wr_data   = 8'($urandom);
    chk("ready_low_after_accept", {31'd0, o_cmd_ready}, 0);
    chk("req_at_T1", {31'd0, (o_bit_req | o_cond_req)}, 1);
    chk("err_cleared_on_accept", {31'd0, o_err}, 0);
  endtask

  task automatic wait_done(output bit got);
    got = 0;
    for (int k = 0; k < 400; k++) begin
      if (o_done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One complete command against the reference: expected bit requests follow
  // from the command code and operands; status follows from the slave reply.
  task automatic do_cmd(input logic [1:0] c, input logic [7:0] wd, input logic ra,
                        input logic [7:0] sbyte, input logic sack);
    bit got;
    logic [8:0] oe, ow, ee, ew;
    sda_q.delete();
    req_we.delete();
    req_wr.delete();
    cond_log.delete();
    if (c == 2'd2) sda_q.push_back(sack);
    if (c == 2'd3) for (int i = 7; i >= 0; i--) sda_q.push_back(sbyte[i]);
    req_rises = 0;
    issue(c, wd, ra);
    wait_done(got);
    chk("done_seen", {31'd0, got}, 1);
    chk("err_at_done", {31'd0, o_err}, 0);
    if (c[1]) begin
      model_ack = (c == 2'd2) ? ~sack : model_ack;
      model_rd  = (c == 2'd3) ? sbyte : model_rd;
      oe = '0; ow = '0; ee = '0; ew = '0;
      for (int i = 0; i < 9; i++) begin
        if (i < req_we.size()) begin
          oe[i] = req_we[i];
          ow[i] = req_wr[i];
        end
        if (c == 2'd2) begin
          if (i < 8) begin
            ee[i] = 1'b1;
            ew[i] = wd[7-i];
          end
        end else if (i == 8) begin
          ee[i] = 1'b1;
          ew[i] = ~ra;
        end
      end
      chk("bit_req_count", req_we.size(), 9);
      chk("bit_req_rises", req_rises, 9);
      chk("bit_we_pattern", {23'd0, oe}, {23'd0, ee});
      chk("bit_wr_pattern", {23'd0, ow & ee}, {23'd0, ew});
    end else begin
      chk("cond_count", cond_log.size(), 1);
      if (cond_log.size() > 0) chk("cond_stop", {31'd0, cond_log[0]}, {31'd0, c[0]});
      chk("no_bit_req_in_cond", req_rises, 0);
    end
    chk("rd_data", {24'd0, o_rd_data}, {24'd0, model_rd});
    chk("ack_rcvd", {31'd0, o_ack_rcvd}, {31'd0, model_ack});
    @(negedge clk);
    chk("done_one_cycle", {31'd0, o_done}, 0);
    chk("ready_after_done", {31'd0, o_cmd_ready}, 1);
  endtask

  initial begin
    bit got;
    int n;
    logic [16:0] ov;
    rst_n       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd       = 2'd0;
    i_wr_data   = 8'h00;
    i_rd_ack    = 1'b0;
    #3;
    ov = {o_cmd_ready, o_done, o_err, o_bit_req, o_bit_we, o_bit_wr,
          o_cond_req, o_cond_stop, o_rd_data, o_ack_rcvd};
    chk("reset_outputs", {15'd0, ov}, 32'h10000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: WRITE A5 with slave ACK, then READ 3C with master NACK.
    bit_time = 2; slow = 0;
    do_cmd(2'd2, 8'hA5, 1'b0, 8'h00, 1'b0);
    do_cmd(2'd3, 8'h00, 1'b0, 8'h3C, 1'b0);

    // START, WRITE 66 with slave NACK, STOP.
    overlap = 0;
    cond_dly = 1;
    do_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0);
    do_cmd(2'd2, 8'h66, 1'b0, 8'h00, 1'b1);
    do_cmd(2'd1, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("no_cond_bit_overlap", overlap, 0);

    // Slow ready deassert after acceptance.
    slow = 3;
    do_cmd(2'd2, 8'h5A, 1'b0, 8'h00, 1'b0);
    do_cmd(2'd3, 8'h00, 1'b1, 8'hC3, 1'b0);
    slow = 0;

    // Clock stretch forever: abort after 16 cycles of waiting in BIT_REQ.
    stall = 1;
    repeat (3) @(negedge clk);
    sda_q.delete();
    issue(2'd2, 8'hFF, 1'b0);
    n = 0;
    while (o_bit_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_wait_cycles", n, 16);
    chk("timeout_done", {31'd0, o_done}, 1);
    chk("timeout_err", {31'd0, o_err}, 1);
    chk("timeout_ack_kept", {31'd0, o_ack_rcvd}, {31'd0, model_ack});
    stall = 0;
    repeat (2) @(negedge clk);
    do_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of a READ, while bit 4 is in flight.
    bit_time = 3;
    sda_q.delete();
    req_we.delete();
    req_wr.delete();
    for (int i = 0; i < 8; i++) sda_q.push_back(1'b1);
    issue(2'd3, 8'h00, 1'b1);
    n = 0;
    while (req_we.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit4", {31'd0, (req_we.size() >= 5)}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    ov = {o_cmd_ready, o_done, o_err, o_bit_req, o_bit_we, o_bit_wr,
          o_cond_req, o_cond_stop, o_rd_data, o_ack_rcvd};
    chk("midread_reset_outputs", {15'd0, ov}, 32'h10000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_rises = 0;
    repeat (20) @(negedge clk);
    chk("no_req_after_reset", req_rises, 0);
    chk("ready_after_reset", {31'd0, o_cmd_ready}, 1);
    model_rd  = 8'h00;
    model_ack = 1'b0;

    // Randomized command stream.
    for (int t = 0; t < 24; t++) begin
      bit_time = $urandom_range(4, 1);
      slow     = $urandom_range(3, 0);
      cond_dly = $urandom_range(5, 0);
      do_cmd(2'($urandom_range(3, 0)), 8'($urandom), 1'($urandom),
             8'($urandom), 1'($urandom));
    end
    chk("no_overlap_total", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
